store_drain_queue: RTL and testbench

Committed-store buffer between the core's commit-stage store port and the data-memory write port. Captures one committed store per cycle into a DEPTH-entry FIFO and drains the oldest entry to memory whenever memory accepts it. Reports, for each of the two execute-stage load ports, whether a pending store overlaps the load's word, so the load can be replayed instead of reading stale memory. Committed stores are architecturally final: the queue is never flushed by branch mispredicts, only by reset.

---
 rtl/store_drain_queue.sv | 120 ++++++++++++
 tb/tb_store_drain_queue.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_queue.sv
// Committed-store drain queue: DEPTH-entry FIFO from commit to data memory.
// Flags loads whose word overlaps a pending or arriving store.
package sdq_pkg;
    typedef logic [2:0] ldst_mode_t;
endpackage

module store_drain_queue
    import sdq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_we,
    input  logic [31:0]       in_wa,
    input  logic [31:0]       in_wd,
    input  ldst_mode_t        in_wm,
    output logic              full,
    output logic              overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic              mem_we,
    output logic [31:0]       mem_wa,
    output logic [31:0]       mem_wd,
    output ldst_mode_t        mem_wm,
    input  logic              mem_ready,
    input  logic [31:0]       ld_addr [2],
    output logic [1:0]        ld_hazard
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    ldst_mode_t    r_mode [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_ovf;

    logic          w_deq;
    logic          w_enq;
    logic [CW-1:0] w_cnt_nx;
    logic [1:0]    w_hz;
    logic          w_unused;

    assign w_deq = (r_count != '0) && mem_ready;
    assign w_enq = in_we && ((r_count != CW'(DEPTH)) || w_deq);

    // Next occupancy: simultaneous enq/deq leaves the count unchanged.
    always_comb begin
        w_cnt_nx = r_count;
        if (w_enq && !w_deq) begin
            w_cnt_nx = r_count + CW'(1);
        end else if (w_deq && !w_enq) begin
            w_cnt_nx = r_count - CW'(1);
        end
    end

    // Control state: pointers, occupancy, full and sticky overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_deq) begin
                r_head <= r_head + AW'(1);
            end
            if (w_enq) begin
                r_tail <= r_tail + AW'(1);
            end
            r_count <= w_cnt_nx;
            r_full  <= (w_cnt_nx == CW'(DEPTH));
            if (in_we && !w_enq) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Entry payload; contents are only meaningful while occupied.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= in_wa;
            r_data[r_tail] <= in_wd;
            r_mode[r_tail] <= in_wm;
        end
    end

    // Word-granular overlap against occupied entries and the arriving store.
    always_comb begin
        w_hz = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (({1'b0, AW'(AW'(i) - r_head)} < r_count) &&
                    (r_addr[i][31:2] == ld_addr[p][31:2])) begin
                    w_hz[p] = 1'b1;
                end
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (in_we && (in_wa[31:2] == ld_addr[p][31:2])) begin
                w_hz[p] = 1'b1;
            end
        end
    end

    assign w_unused  = ^{ld_addr[0][1:0], ld_addr[1][1:0]};

    assign full      = r_full;
    assign overflow  = r_ovf;
    assign count     = r_count;
    assign mem_we    = (r_count != '0);
    assign mem_wa    = r_addr[r_head];
    assign mem_wd    = r_data[r_head];
    assign mem_wm    = r_mode[r_head];
    assign ld_hazard = w_hz;
endmodule

// File: tb/tb_store_drain_queue.sv
// Directed bench for store_drain_queue with a queue-based reference model.
// Model is checked every cycle; literal expectations pin the scenarios.
module tb_store_drain_queue;
    import sdq_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  m;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        in_we;
    logic [31:0] in_wa;
    logic [31:0] in_wd;
    ldst_mode_t  in_wm;
    logic        full;
    logic        overflow;
    logic [2:0]  count;
    logic        mem_we;
    logic [31:0] mem_wa;
    logic [31:0] mem_wd;
    ldst_mode_t  mem_wm;
    logic        mem_ready;
    logic [31:0] ld_addr [2];
    logic [1:0]  ld_hazard;

    ent_t        mq[$];
    logic        m_ovf;
    logic [31:0] drained[$];
    int          n_tot;
    int          n_pass;

    store_drain_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_we     (in_we),
        .in_wa     (in_wa),
        .in_wd     (in_wd),
        .in_wm     (in_wm),
        .full      (full),
        .overflow  (overflow),
        .count     (count),
        .mem_we    (mem_we),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .mem_wm    (mem_wm),
        .mem_ready (mem_ready),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    // Compare every visible output to the model at the current instant.
    task automatic model_check();
        logic [1:0] h;
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == 4));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("mem_we", 32'(mem_we), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("mem_wa", mem_wa, mq[0].a);
            chk("mem_wd", mem_wd, mq[0].d);
            chk("mem_wm", 32'(mem_wm), 32'(mq[0].m));
        end
        h = '0;
        for (int p = 0; p < 2; p++) begin
            foreach (mq[i]) begin
                if ((mq[i].a >> 2) == (ld_addr[p] >> 2)) h[p] = 1'b1;
            end
            if (in_we && ((in_wa >> 2) == (ld_addr[p] >> 2))) h[p] = 1'b1;
        end
        chk("ld_hazard", 32'(ld_hazard), 32'(h));
    endtask

    // One clock: check at negedge, advance model, step past posedge.
    task automatic step();
        bit   deq;
        bit   enq;
        ent_t e;
        @(negedge clk);
        model_check();
        if (mem_we && mem_ready) drained.push_back(mem_wa);
        deq = (mq.size() != 0) && mem_ready;
        enq = in_we && ((mq.size() < 4) || deq);
        if (deq) void'(mq.pop_front());
        if (enq) begin
            e.a = in_wa;
            e.d = in_wd;
            e.m = in_wm;
            mq.push_back(e);
        end else if (in_we) begin
            m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] a);
        in_we = 1'b1;
        in_wa = a;
        in_wd = a ^ 32'hA5A5_0000;
        in_wm = ldst_mode_t'(a[4:2]);
    endtask

    task automatic idle();
        in_we = 1'b0;
        in_wa = '0;
        in_wd = '0;
        in_wm = '0;
    endtask

    task automatic chk_drain(input string n, input logic [31:0] exp[$]);
        chk({n, "_len"}, 32'(drained.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < drained.size()) chk(n, drained[i], exp[i]);
        end
        drained.delete();
    endtask

    initial begin
        logic [31:0] exp[$];
        n_tot = 0;
        n_pass = 0;
        m_ovf = 1'b0;
        reset = 1'b0;
        mem_ready = 1'b0;
        ld_addr[0] = 32'hFFFF_FFF0;
        ld_addr[1] = 32'hFFFF_FFF0;
        idle();
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_hz", 32'(ld_hazard), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // Single store held, then drained.
        put(32'h100);
        in_wd = 32'hDEAD_BEEF;
        step();
        idle();
        chk("ss_mem_we", 32'(mem_we), 1);
        chk("ss_wa", mem_wa, 32'h100);
        chk("ss_wd", mem_wd, 32'hDEAD_BEEF);
        chk("ss_cnt", 32'(count), 1);
        repeat (3) step();
        chk("ss_hold", mem_wa, 32'h100);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("ss_done_we", 32'(mem_we), 0);
        chk("ss_done_cnt", 32'(count), 0);
        drained.delete();

        // Fill past capacity, then drain in order.
        for (int i = 0; i < 5; i++) begin
            put(32'(i * 4));
            step();
        end
        idle();
        chk("fill_cnt", 32'(count), 4);
        chk("fill_full", 32'(full), 1);
        chk("fill_ovf", 32'(overflow), 1);
        mem_ready = 1'b1;
        repeat (5) step();
        chk("fill_empty", 32'(mem_we), 0);
        chk("fill_ovf_sticky", 32'(overflow), 1);
        exp = '{32'h0, 32'h4, 32'h8, 32'hC};
        chk_drain("fill_order", exp);
        mem_ready = 1'b0;

        // Asynchronous reset with three entries pending.
        for (int i = 0; i < 3; i++) begin
            put(32'h80 + 32'(i * 4));
            step();
        end
        idle();
        chk("pre_rst_cnt", 32'(count), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_we", 32'(mem_we), 0);
        chk("arst_cnt", 32'(count), 0);
        chk("arst_full", 32'(full), 0);
        chk("arst_ovf", 32'(overflow), 0);
        mq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        put(32'h300);
        step();
        idle();
        chk("post_rst_wa", mem_wa, 32'h300);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        drained.delete();

        // Full queue with concurrent enqueue and dequeue.
        for (int i = 0; i < 4; i++) begin
            put(32'h20 + 32'(i * 4));
            step();
        end
        chk("fc_full", 32'(full), 1);
        put(32'h40);
        mem_ready = 1'b1;
        step();
        idle();
        chk("fc_cnt", 32'(count), 4);
        chk("fc_ovf", 32'(overflow), 0);
        repeat (5) step();
        exp = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h40};
        chk_drain("fc_order", exp);

        // Streaming through pointer wrap.
        for (int i = 0; i < 10; i++) begin
            put(32'h1000 + 32'(i * 4));
            step();
            chk("wrap_cnt_le1", 32'(count <= 1), 1);
        end
        idle();
        step();
        chk("wrap_ovf", 32'(overflow), 0);
        exp.delete();
        for (int i = 0; i < 10; i++) exp.push_back(32'h1000 + 32'(i * 4));
        chk_drain("wrap_order", exp);
        mem_ready = 1'b0;

        // Hazard detection against pending and arriving stores.
        put(32'h200);
        step();
        idle();
        ld_addr[0] = 32'h203;
        ld_addr[1] = 32'h204;
        #2;
        chk("hz_pending", 32'(ld_hazard), 32'b01);
        step();
        put(32'h204);
        #2;
        chk("hz_arriving", 32'(ld_hazard), 32'b11);
        step();
        idle();
        mem_ready = 1'b1;
        #2;
        chk("hz_leaving", 32'(ld_hazard), 32'b11);
        step();
        step();
        chk("hz_clear", 32'(ld_hazard), 32'b00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
